cla_checker_multimode: RTL and testbench

// - Self-checking on-chip stimulus/check harness for pipelined_adder, generalised in width and stage count.
// - Runs a bounded test session in one of three modes and keeps an expected-result queue, so any adder latency is checked.
// - Reports sticky error, saturating error count and index of first failing vector.
// - Sits between board-level start/status logic (buttons/ILA) and one pipelined_adder instance.

---
 rtl/cla_chk_pkg.sv | 48 ++++
 rtl/cla_checker_multimode_if.sv | 45 ++++
 rtl/cla_chk_exp_fifo.sv | 41 ++++
 rtl/pipelined_adder.sv | 36 +++
 rtl/cla_checker_multimode.sv | 187 ++++++++++++++++++
 tb/tb_cla_checker_multimode.sv | 204 ++++++++++++++++++++
 6 files changed

// File: rtl/cla_chk_pkg.sv
// Shared types and helpers for the pipelined-adder checker: mode and FSM encodings,
// the Galois LFSR step used by both operand generators.
package cla_chk_pkg;

    localparam int CNT_W_DEF  = 32;
    localparam int LFSR_MAX_W = 256;

    typedef enum logic [1:0] {
        MODE_COMPL = 2'd0,
        MODE_RAND  = 2'd1,
        MODE_CARRY = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Right-shifting Galois feedback mask; maximal-length taps for common widths,
    // a two-tap fallback otherwise (still never locks up from a nonzero seed).
    function automatic logic [LFSR_MAX_W-1:0] lfsr_mask(input int unsigned w);
        logic [LFSR_MAX_W-1:0] m;
        logic [7:0]            hi;
        m  = '0;
        hi = 8'(w - 1);
        case (w)
            8:       begin m[7]   = 1'b1; m[5]   = 1'b1; m[4]   = 1'b1; m[3]  = 1'b1; end
            16:      begin m[15]  = 1'b1; m[14]  = 1'b1; m[12]  = 1'b1; m[3]  = 1'b1; end
            32:      begin m[31]  = 1'b1; m[21]  = 1'b1; m[1]   = 1'b1; m[0]  = 1'b1; end
            64:      begin m[63]  = 1'b1; m[62]  = 1'b1; m[60]  = 1'b1; m[59] = 1'b1; end
            128:     begin m[127] = 1'b1; m[125] = 1'b1; m[100] = 1'b1; m[98] = 1'b1; end
            default: begin m[hi]  = 1'b1; m[hi - 8'd1] = 1'b1; end
        endcase
        return m;
    endfunction

    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] cur,
                                                         input int unsigned           w);
        logic [LFSR_MAX_W-1:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) nxt = nxt ^ lfsr_mask(w);
        return nxt;
    endfunction

endpackage

// File: rtl/cla_checker_multimode_if.sv
// Control/status bus between board-level session logic (master) and the checker (slave).
// CLA_CHK_CAPTURE_EN adds the first-mismatch capture outputs.
interface cla_checker_multimode_if
    import cla_chk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
`ifdef CLA_CHK_CAPTURE_EN
    , parameter int W = 128
`endif
);
    // start is a single-cycle request; it is only honoured when dbg_state is IDLE or DONE.
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] num_vectors;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] first_err_idx;
    logic             q_fault;
    state_t           dbg_state;
`ifdef CLA_CHK_CAPTURE_EN
    logic [W-1:0]     cap_op1;
    logic [W-1:0]     cap_op2;
    logic [W-1:0]     cap_res;
    logic [W-1:0]     cap_exp;
`endif

    modport master (
        output start, mode, num_vectors,
        input  busy, done, error, err_count, first_err_idx, q_fault, dbg_state
`ifdef CLA_CHK_CAPTURE_EN
        , input cap_op1, cap_op2, cap_res, cap_exp
`endif
    );

    modport slave (
        input  start, mode, num_vectors,
        output busy, done, error, err_count, first_err_idx, q_fault, dbg_state
`ifdef CLA_CHK_CAPTURE_EN
        , output cap_op1, cap_op2, cap_res, cap_exp
`endif
    );

endinterface

// File: rtl/cla_chk_exp_fifo.sv
// Expected-result queue: synchronous FIFO with full/empty, same-cycle push/pop, and clear.
module cla_chk_exp_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pipelined_adder.sv
// W-bit adder with an s-cycle latency; the sum is formed at entry and the trailing
// register stages are left for retiming to balance. Carry-out is not produced.
module pipelined_adder #(
    parameter int w = 128,
    parameter int s = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         valid_op1,
    input  logic         valid_op2,
    input  logic [w-1:0] op1,
    input  logic [w-1:0] op2,
    output logic [w-1:0] res,
    output logic         valid
);
    logic [w-1:0] sum_q [s];
    logic [s-1:0] v_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v_q <= '0;
        end else begin
            v_q[0] <= valid_op1 & valid_op2;
            for (int i = 1; i < s; i++) v_q[i] <= v_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        sum_q[0] <= op1 + op2;
        for (int i = 1; i < s; i++) sum_q[i] <= sum_q[i-1];
    end

    assign res   = sum_q[s-1];
    assign valid = v_q[s-1];

endmodule

// File: rtl/cla_checker_multimode.sv
// Session-based stimulus/check harness around one pipelined_adder (COMPL/RAND/CARRY modes).
// Define CLA_CHK_CAPTURE_EN to latch operands, result and expected value of the first mismatch.
module cla_checker_multimode
    import cla_chk_pkg::*;
#(
    parameter int           W      = 128,
    parameter int           S      = 4,
    parameter int           QD     = 8,       // must be a power of 2 and >= S+2
    parameter int           CNT_W  = CNT_W_DEF,
    parameter logic [W-1:0] SEED_A = W'('h1),
    parameter logic [W-1:0] SEED_B = W'('h5A5)
) (
    input  logic                    clk,
    input  logic                    rst,
    cla_checker_multimode_if.slave  bus
);
    localparam int KW = (W > 1) ? $clog2(W) : 1;
`ifdef CLA_CHK_CAPTURE_EN
    localparam int QW = 3 * W;
`else
    localparam int QW = W;
`endif

    state_t           state;
    mode_t            mode_q;
    logic [CNT_W-1:0] n_vec, issued, checked, err_count, first_err_idx;
    logic             busy_q, done_q, error_q, q_fault_q;
    logic [W-1:0]     lfsr_a, lfsr_b;
    logic [KW-1:0]    k_idx;
    logic [W-1:0]     gen_op1, gen_op2, gen_exp, q_exp, add_res;
    logic [QW-1:0]    q_din, q_dout;
    logic             q_full, q_empty, add_valid;
    logic             accept, issue, mismatch;

    assign accept   = bus.start && (state == ST_IDLE || state == ST_DONE);
    assign issue    = (state == ST_RUN) && !q_full && (issued != n_vec);
    assign mismatch = add_valid && !q_empty && (q_exp != add_res);

    always_comb begin
        gen_op1 = lfsr_a;
        gen_op2 = ~lfsr_a;
        case (mode_q)
            MODE_RAND:  gen_op2 = lfsr_b;
            MODE_CARRY: begin
                gen_op1 = '1;
                gen_op2 = W'(1) << k_idx;
            end
            default: ;
        endcase
    end
    assign gen_exp = gen_op1 + gen_op2;

`ifdef CLA_CHK_CAPTURE_EN
    assign q_din = {gen_op1, gen_op2, gen_exp};
    assign q_exp = q_dout[W-1:0];
`else
    assign q_din = gen_exp;
    assign q_exp = q_dout;
`endif

    cla_chk_exp_fifo #(.WIDTH(QW), .DEPTH(QD)) u_exp_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .push  (issue),
        .din   (q_din),
        .pop   (add_valid),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );

    pipelined_adder #(.w(W), .s(S)) u_adder (
        .clk       (clk),
        .rstn      (~rst),
        .valid_op1 (issue),
        .valid_op2 (issue),
        .op1       (gen_op1),
        .op2       (gen_op2),
        .res       (add_res),
        .valid     (add_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            mode_q        <= MODE_COMPL;
            n_vec         <= '0;
            issued        <= '0;
            checked       <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            q_fault_q     <= 1'b0;
            lfsr_a        <= SEED_A;
            lfsr_b        <= SEED_B;
            k_idx         <= '0;
        end else begin
            // A result with nothing queued is still counted so the drain can finish.
            if (add_valid) begin
                checked <= checked + 1'b1;
                if (q_empty) begin
                    q_fault_q <= 1'b1;
                    error_q   <= 1'b1;
                end else if (mismatch) begin
                    error_q <= 1'b1;
                    if (err_count != '1) err_count <= err_count + 1'b1;
                    if (err_count == '0) first_err_idx <= checked;
                end
            end
            if (issue) begin
                issued <= issued + 1'b1;
                lfsr_a <= W'(lfsr_next(LFSR_MAX_W'(lfsr_a), W));
                lfsr_b <= W'(lfsr_next(LFSR_MAX_W'(lfsr_b), W));
                k_idx  <= (k_idx == KW'(W - 1)) ? '0 : k_idx + 1'b1;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state         <= ST_RUN;
                        mode_q        <= mode_t'(bus.mode);
                        n_vec         <= bus.num_vectors;
                        issued        <= '0;
                        checked       <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        error_q       <= 1'b0;
                        q_fault_q     <= 1'b0;
                        k_idx         <= '0;
                        busy_q        <= (bus.num_vectors != '0);
                        done_q        <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (issued == n_vec) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (issue && (issued + 1'b1 == n_vec)) begin
                        state <= ST_DRAIN;
                    end
                end
                default: begin
                    if (checked >= n_vec) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef CLA_CHK_CAPTURE_EN
    logic [W-1:0] cap_op1_q, cap_op2_q, cap_res_q, cap_exp_q;

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            cap_op1_q <= '0;
            cap_op2_q <= '0;
            cap_res_q <= '0;
            cap_exp_q <= '0;
        end else if (mismatch && err_count == '0) begin
            cap_op1_q <= q_dout[3*W-1:2*W];
            cap_op2_q <= q_dout[2*W-1:W];
            cap_res_q <= add_res;
            cap_exp_q <= q_exp;
        end
    end

    assign bus.cap_op1 = cap_op1_q;
    assign bus.cap_op2 = cap_op2_q;
    assign bus.cap_res = cap_res_q;
    assign bus.cap_exp = cap_exp_q;
`endif

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;
    assign bus.err_count     = err_count;
    assign bus.first_err_idx = first_err_idx;
    assign bus.q_fault       = q_fault_q;
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_cla_checker_multimode.sv
// Directed bench for cla_checker_multimode: reset, long COMPL run, CARRY wrap, injected
// result fault, empty session, mid-run reset and spurious adder valid.
module tb_cla_checker_multimode;
    import cla_chk_pkg::*;

    localparam int W     = 128;
    localparam int S     = 4;
    localparam int QD    = 8;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cla_checker_multimode_if #(
        .CNT_W(CNT_W)
`ifdef CLA_CHK_CAPTURE_EN
        , .W(W)
`endif
    ) bus ();

    cla_checker_multimode #(.W(W), .S(S), .QD(QD), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] exp_q[$];

    task automatic start_session(input logic [1:0] m, input int n);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.mode        = m;
        bus.num_vectors = CNT_W'(n);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < budget && !ok) begin
            @(negedge clk);
            cyc++;
            if (bus.done) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", bus.error); end
        checks++; if (bus.err_count !== '0) begin errors++; $display("FAIL reset_err_count got %0d want 0", bus.err_count); end
        checks++; if (bus.first_err_idx !== '0) begin errors++; $display("FAIL reset_first_idx got %0d want 0", bus.first_err_idx); end
        checks++; if (bus.q_fault !== 1'b0) begin errors++; $display("FAIL reset_q_fault got %b want 0", bus.q_fault); end
        checks++; if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", bus.dbg_state); end
        rst = 1'b0;
    endtask

    task automatic test_compl;
        int cyc; bit ok;
        start_session(2'd0, 1000);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL compl_busy got %b want 1", bus.busy); end
        wait_done(1100, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL compl_done timeout after %0d cycles", cyc); end
        checks++; if (cyc < 1000 || cyc > 1000 + S + 10) begin errors++; $display("FAIL compl_latency got %0d want 1000..%0d", cyc, 1000 + S + 10); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL compl_error got %b want 0", bus.error); end
        checks++; if (bus.err_count !== '0) begin errors++; $display("FAIL compl_err_count got %0d want 0", bus.err_count); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL compl_busy_end got %b want 0", bus.busy); end
    endtask

    task automatic test_carry;
        int cyc; int ridx; logic [W-1:0] one; logic [W-1:0] want;
        one = 1;
        for (int i = 0; i < 256; i++) exp_q.push_back((one << (i % W)) - one);
        start_session(2'd2, 256);
        ridx = 0;
        cyc  = 0;
        while (cyc < 400 && !bus.done) begin
            @(negedge clk);
            cyc++;
            if (dut.add_valid) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                checks++;
                if (dut.add_res !== want) begin
                    errors++;
                    $display("FAIL carry_res[%0d] got %h want %h", ridx, dut.add_res, want);
                end
                ridx++;
            end
        end
        checks++; if (!bus.done) begin errors++; $display("FAIL carry_done timeout after %0d cycles", cyc); end
        checks++; if (ridx != 256) begin errors++; $display("FAIL carry_count got %0d want 256", ridx); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL carry_error got %b want 0", bus.error); end
        exp_q.delete();
    endtask

    task automatic test_fault_inject;
        int cyc; int ridx; logic [W-1:0] good; logic [W-1:0] bad; logic [W-1:0] one;
        one  = 1;
        good = '0;
        bad  = '0;
        start_session(2'd1, 40);
        ridx = 0;
        cyc  = 0;
        while (cyc < 200 && !bus.done) begin
            @(negedge clk);
            cyc++;
            if (dut.add_valid) begin
                if (ridx == 17) begin
                    good = dut.add_res;
                    bad  = good ^ (one << 5);
                    force dut.add_res = bad;
                    @(posedge clk);
                    #1 release dut.add_res;
                end
                ridx++;
            end
        end
        checks++; if (!bus.done) begin errors++; $display("FAIL inj_done timeout after %0d cycles", cyc); end
        checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL inj_error got %b want 1", bus.error); end
        checks++; if (bus.err_count !== 32'd1) begin errors++; $display("FAIL inj_err_count got %0d want 1", bus.err_count); end
        checks++; if (bus.first_err_idx !== 32'd17) begin errors++; $display("FAIL inj_first_idx got %0d want 17", bus.first_err_idx); end
        checks++; if (bus.q_fault !== 1'b0) begin errors++; $display("FAIL inj_q_fault got %b want 0", bus.q_fault); end
`ifdef CLA_CHK_CAPTURE_EN
        checks++; if (bus.cap_res !== bad) begin errors++; $display("FAIL cap_res got %h want %h", bus.cap_res, bad); end
        checks++; if (bus.cap_exp !== good) begin errors++; $display("FAIL cap_exp got %h want %h", bus.cap_exp, good); end
        checks++; if (bus.cap_op1 + bus.cap_op2 !== good) begin errors++; $display("FAIL cap_ops sum got %h want %h", bus.cap_op1 + bus.cap_op2, good); end
`endif
    endtask

    task automatic test_zero_vectors;
        int busy_seen;
        busy_seen = 0;
        start_session(2'd0, 0);
        if (bus.busy) busy_seen++;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_done_early got %b want 0", bus.done); end
        @(negedge clk);
        if (bus.busy) busy_seen++;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", bus.done); end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL zero_busy got %0d want 0", busy_seen); end
        checks++; if (bus.err_count !== '0) begin errors++; $display("FAIL zero_err_count got %0d want 0", bus.err_count); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL zero_error got %b want 0", bus.error); end
    endtask

    task automatic test_reset_mid_run;
        int cyc; int nres;
        start_session(2'd0, 1000);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus.done); end
        start_session(2'd0, 10);
        nres = 0;
        cyc  = 0;
        while (cyc < 100 && !bus.done) begin
            @(negedge clk);
            cyc++;
            if (dut.add_valid) nres++;
        end
        checks++; if (!bus.done) begin errors++; $display("FAIL midrst_done2 timeout after %0d cycles", cyc); end
        checks++; if (nres != 10) begin errors++; $display("FAIL midrst_results got %0d want 10", nres); end
        checks++; if (bus.q_fault !== 1'b0) begin errors++; $display("FAIL midrst_q_fault got %b want 0", bus.q_fault); end
        checks++; if (bus.err_count !== '0) begin errors++; $display("FAIL midrst_err_count got %0d want 0", bus.err_count); end
    endtask

    task automatic test_spurious_valid;
        @(negedge clk);
        force dut.add_valid = 1'b1;
        @(posedge clk);
        #1 release dut.add_valid;
        @(negedge clk);
        checks++; if (bus.q_fault !== 1'b1) begin errors++; $display("FAIL spur_q_fault got %b want 1", bus.q_fault); end
        checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL spur_error got %b want 1", bus.error); end
        checks++; if (bus.err_count !== '0) begin errors++; $display("FAIL spur_err_count got %0d want 0", bus.err_count); end
        start_session(2'd0, 4);
        checks++; if (bus.q_fault !== 1'b0 || bus.error !== 1'b0) begin errors++; $display("FAIL spur_clear got %b%b want 00", bus.q_fault, bus.error); end
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.mode        = 2'd0;
        bus.num_vectors = '0;
        test_reset();
        test_compl();
        test_carry();
        test_fault_inject();
        test_zero_vectors();
        test_reset_mid_run();
        test_spurious_valid();
        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
